lsu_mem_initiator: RTL and testbench

- Initiator side of the core's word-wide data-memory port: memory is 32-bit words with 4 byte-write-enables and registered 1-cycle read latency.
- Accepts one RV32I load/store request at a time from the execute stage.
- Converts it into word-aligned memory accesses with byte masks and shifted write data.
- Extracts and sign/zero-extends load data, and reports misaligned or illegal accesses instead of touching memory.

---
 rtl/lsu_mem_initiator.sv | 163 ++++++++++++++++
 tb/tb_lsu_mem_initiator.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_initiator.sv
// Load/store initiator for a word-wide data memory with byte enables and 1-cycle read latency.
// Handles one RV32I request at a time: decode, issue, optional read wait, response handshake.
//
// state | meaning
// IDLE  | ready for a request; decode and check alignment/funct3 on acceptance
// ISSUE | memory address/byte mask/write data presented for exactly one cycle
// WAIT  | load data returning from memory; extract and extend it
// RESP  | response held until the consumer takes it
module lsu_mem_initiator #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [31:0]           resp_rdata,
    output logic                  resp_error,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [31:0]           mem_write_data,
    output logic [3:0]            mem_write_enable,
    input  logic [31:0]           mem_read_data
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t     state;
    logic       cap_write;
    logic [2:0] cap_funct3;
    logic [1:0] cap_lo;

    logic        bad_funct3;
    logic        misaligned;
    logic        req_err;
    logic [1:0]  lo;
    logic [3:0]  st_we;
    logic [31:0] st_data;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_ext;

    assign lo = req_addr[1:0];

    always_comb begin
        bad_funct3 = 1'b0;
        misaligned = 1'b0;
        if (req_write) begin
            bad_funct3 = (req_funct3 > 3'd2);
        end else begin
            bad_funct3 = !((req_funct3 == 3'd0) || (req_funct3 == 3'd1) || (req_funct3 == 3'd2) ||
                           (req_funct3 == 3'd4) || (req_funct3 == 3'd5));
        end
        if (req_funct3[1:0] == 2'd1) begin
            misaligned = lo[0];
        end else if (req_funct3[1:0] == 2'd2) begin
            misaligned = (lo != 2'd0);
        end
        req_err = bad_funct3 || misaligned;
    end

    // Store lane steering; only meaningful when the request is legal.
    always_comb begin
        st_we   = 4'b1111;
        st_data = req_wdata;
        case (req_funct3[1:0])
            2'd0: begin
                st_we   = 4'b0001 << lo;
                st_data = {24'd0, req_wdata[7:0]} << {lo, 3'b000};
            end
            2'd1: begin
                st_we   = lo[1] ? 4'b1100 : 4'b0011;
                st_data = lo[1] ? {req_wdata[15:0], 16'd0} : {16'd0, req_wdata[15:0]};
            end
            default: begin
                st_we   = 4'b1111;
                st_data = req_wdata;
            end
        endcase
    end

    always_comb begin
        ld_byte = mem_read_data[{cap_lo, 3'b000} +: 8];
        ld_half = cap_lo[1] ? mem_read_data[31:16] : mem_read_data[15:0];
        case (cap_funct3)
            3'd0:    ld_ext = {{24{ld_byte[7]}}, ld_byte};
            3'd1:    ld_ext = {{16{ld_half[15]}}, ld_half};
            3'd4:    ld_ext = {24'd0, ld_byte};
            3'd5:    ld_ext = {16'd0, ld_half};
            default: ld_ext = mem_read_data;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= IDLE;
            req_ready        <= 1'b1;
            resp_valid       <= 1'b0;
            resp_rdata       <= 32'd0;
            resp_error       <= 1'b0;
            mem_address      <= '0;
            mem_write_data   <= 32'd0;
            mem_write_enable <= 4'd0;
            cap_write        <= 1'b0;
            cap_funct3       <= 3'd0;
            cap_lo           <= 2'd0;
        end else begin
            // Byte enables are a one-cycle pulse; only the accepting edge raises them.
            mem_write_enable <= 4'd0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        cap_write  <= req_write;
                        cap_funct3 <= req_funct3;
                        cap_lo     <= lo;
                        req_ready  <= 1'b0;
                        if (req_err) begin
                            resp_error <= 1'b1;
                            resp_rdata <= 32'd0;
                            resp_valid <= 1'b1;
                            state      <= RESP;
                        end else begin
                            resp_error  <= 1'b0;
                            mem_address <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
                            if (req_write) begin
                                mem_write_enable <= st_we;
                                mem_write_data   <= st_data;
                            end
                            state <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (cap_write) begin
                        resp_rdata <= 32'd0;
                        resp_valid <= 1'b1;
                        state      <= RESP;
                    end else begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    resp_rdata <= ld_ext;
                    resp_valid <= 1'b1;
                    state      <= RESP;
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Randomized and directed bench for lsu_mem_initiator against a byte-level memory model.
module tb_lsu_mem_initiator;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_error;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic [3:0]  mem_write_enable;
    logic [31:0] mem_read_data;

    int n_vec  = 0;
    int n_fail = 0;

    logic [31:0] mem     [0:255];
    logic [31:0] ref_mem [0:255];

    lsu_mem_initiator #(.ADDR_WIDTH(32)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
        .resp_error(resp_error), .mem_address(mem_address), .mem_write_data(mem_write_data),
        .mem_write_enable(mem_write_enable), .mem_read_data(mem_read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word memory with byte enables and registered read.
    always @(posedge clk) begin
        for (int b = 0; b < 4; b++)
            if (mem_write_enable[b]) mem[mem_address[9:2]][8*b +: 8] <= mem_write_data[8*b +: 8];
        mem_read_data <= mem[mem_address[9:2]];
    end

    // Reference: access size from funct3, legality, lane placement and extension by arithmetic.
    function automatic void model(input logic w, input logic [2:0] f3, input logic [31:0] addr,
                                  input logic [31:0] wd, input logic commit,
                                  output logic err, output logic [31:0] rd, output logic [3:0] we,
                                  output logic [31:0] data, output int lat);
        int nb, off, idx;
        logic [63:0] mask, v;
        nb   = 1 << f3[1:0];
        off  = int'(addr % 4);
        idx  = int'(addr[9:2]);
        mask = (nb >= 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * nb)) - 64'd1);
        err  = w ? (f3 > 3'd2) : !(f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        if ((addr % nb) != 0) err = 1'b1;
        rd = 32'd0; we = 4'd0; data = 32'd0; lat = 1;
        if (err) begin
            lat = 1;
        end else if (w) begin
            we   = 4'(((1 << nb) - 1) << off);
            v    = ({32'd0, wd} & mask) << (8 * off);
            data = v[31:0];
            if (commit)
                for (int b = 0; b < 4; b++)
                    if (we[b]) ref_mem[idx][8*b +: 8] = data[8*b +: 8];
            lat = 2;
        end else begin
            v = ({32'd0, ref_mem[idx]} >> (8 * off)) & mask;
            if (f3 < 3'd4 && v >= ((mask + 64'd1) >> 1)) v = v | ~mask;
            rd  = v[31:0];
            lat = 3;
        end
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        n_vec += 7;
        if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready got %b want 1", req_ready); end
        if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_resp_valid got %b want 0", resp_valid); end
        if (resp_error !== 1'b0) begin n_fail++; $display("FAIL reset_resp_error got %b want 0", resp_error); end
        if (resp_rdata !== 32'd0) begin n_fail++; $display("FAIL reset_resp_rdata got %h want 0", resp_rdata); end
        if (mem_address !== 32'd0) begin n_fail++; $display("FAIL reset_mem_address got %h want 0", mem_address); end
        if (mem_write_data !== 32'd0) begin n_fail++; $display("FAIL reset_mem_wdata got %h want 0", mem_write_data); end
        if (mem_write_enable !== 4'd0) begin n_fail++; $display("FAIL reset_mem_we got %b want 0", mem_write_enable); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_txn(input logic w, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] wd, input string name);
        logic err; logic [31:0] rd; logic [3:0] we; logic [31:0] data; int lat; int seen;
        int waited;
        model(w, f3, addr, wd, 1'b1, err, rd, we, data, lat);
        waited = 0;
        while (req_ready !== 1'b1 && waited < 20) begin @(negedge clk); waited++; end
        n_vec++;
        if (req_ready !== 1'b1) begin n_fail++; $display("FAIL %s ready_timeout got %b want 1", name, req_ready); return; end
        req_valid = 1'b1; req_write = w; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        @(posedge clk);
        #1 req_valid = 1'b0;
        seen = 1;
        @(negedge clk);
        while (seen <= 8) begin
            n_vec++;
            if (seen == 1 && !err) begin
                n_vec++;
                if (mem_address !== {addr[31:2], 2'b00}) begin
                    n_fail++; $display("FAIL %s mem_address got %h want %h", name, mem_address, {addr[31:2], 2'b00});
                end
                if (mem_write_enable !== we) begin
                    n_fail++; $display("FAIL %s mem_we got %b want %b", name, mem_write_enable, we);
                end
                if (w) begin
                    n_vec++;
                    if (mem_write_data !== data) begin
                        n_fail++; $display("FAIL %s mem_wdata got %h want %h", name, mem_write_data, data);
                    end
                end
            end else if (mem_write_enable !== 4'd0) begin
                n_fail++; $display("FAIL %s we_outside_issue cycle %0d got %b want 0000", name, seen, mem_write_enable);
            end
            if (resp_valid === 1'b1) break;
            @(negedge clk);
            seen++;
        end
        n_vec += 4;
        if (seen !== lat) begin n_fail++; $display("FAIL %s latency got %0d want %0d", name, seen, lat); end
        if (resp_rdata !== rd) begin n_fail++; $display("FAIL %s rdata got %h want %h", name, resp_rdata, rd); end
        if (resp_error !== err) begin n_fail++; $display("FAIL %s error got %b want %b", name, resp_error, err); end
        if (req_ready !== 1'b0) begin n_fail++; $display("FAIL %s ready_in_resp got %b want 0", name, req_ready); end
        @(negedge clk);
        n_vec += 2;
        if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL %s resp_drop got %b want 0", name, resp_valid); end
        if (req_ready !== 1'b1) begin n_fail++; $display("FAIL %s ready_back got %b want 1", name, req_ready); end
    endtask

    task automatic test_directed();
        mem[8'h10] = 32'h8899AABB; ref_mem[8'h10] = 32'h8899AABB;
        test_txn(1'b0, 3'd2, 32'h40, 32'd0, "lw_40");
        test_txn(1'b0, 3'd0, 32'h43, 32'd0, "lb_43");
        test_txn(1'b0, 3'd4, 32'h43, 32'd0, "lbu_43");
        test_txn(1'b0, 3'd1, 32'h42, 32'd0, "lh_42");
        test_txn(1'b0, 3'd5, 32'h40, 32'd0, "lhu_40");
        test_txn(1'b1, 3'd1, 32'h06, 32'h1234ABCD, "sh_06");
        test_txn(1'b0, 3'd2, 32'h04, 32'd0, "lw_04_readback");
        test_txn(1'b1, 3'd0, 32'h09, 32'h000000EE, "sb_09");
        test_txn(1'b0, 3'd2, 32'h102, 32'd0, "lw_misaligned");
        test_txn(1'b1, 3'd1, 32'h05, 32'h5555, "sh_misaligned");
        test_txn(1'b0, 3'd3, 32'h40, 32'd0, "load_f3_3");
        test_txn(1'b1, 3'd4, 32'h40, 32'd0, "store_f3_4");
    endtask

    task automatic test_random();
        logic w; logic [2:0] f3; logic [31:0] a;
        for (int i = 0; i < 80; i++) begin
            w  = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            a  = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (f3[1:0] == 2'd1) a[0] = 1'b0;
                if (f3[1:0] == 2'd2) a[1:0] = 2'd0;
            end
            test_txn(w, f3, a, $urandom, "random");
        end
    endtask

    task automatic test_backpressure();
        logic err; logic [31:0] rd; logic [3:0] we; logic [31:0] data; int lat; int waited;
        logic [31:0] word_before;
        model(1'b0, 3'd2, 32'h40, 32'd0, 1'b0, err, rd, we, data, lat);
        word_before = ref_mem[8'h20];
        resp_ready = 1'b0;
        req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'd2; req_addr = 32'h40; req_wdata = 32'd0;
        @(posedge clk);
        #1 req_valid = 1'b0;
        waited = 0;
        @(negedge clk);
        while (resp_valid !== 1'b1 && waited < 8) begin @(negedge clk); waited++; end
        n_vec++;
        if (resp_valid !== 1'b1) begin n_fail++; $display("FAIL hold_resp_timeout got %b want 1", resp_valid); end
        // A store offered while busy must be ignored.
        req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'd2; req_addr = 32'h80; req_wdata = 32'hCAFEF00D;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_vec += 4;
            if (resp_valid !== 1'b1) begin n_fail++; $display("FAIL hold_valid c%0d got %b want 1", c, resp_valid); end
            if (resp_rdata !== rd) begin n_fail++; $display("FAIL hold_rdata c%0d got %h want %h", c, resp_rdata, rd); end
            if (req_ready !== 1'b0) begin n_fail++; $display("FAIL hold_ready c%0d got %b want 0", c, req_ready); end
            if (mem_write_enable !== 4'd0) begin n_fail++; $display("FAIL hold_we c%0d got %b want 0000", c, mem_write_enable); end
        end
        req_valid = 1'b0;
        resp_ready = 1'b1;
        repeat (3) @(negedge clk);
        n_vec += 3;
        if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL hold_release_valid got %b want 0", resp_valid); end
        if (req_ready !== 1'b1) begin n_fail++; $display("FAIL hold_release_ready got %b want 1", req_ready); end
        if (mem[8'h20] !== word_before) begin n_fail++; $display("FAIL hold_ignored_store got %h want %h", mem[8'h20], word_before); end
    endtask

    task automatic test_reset_midop();
        logic [31:0] word_before;
        word_before = ref_mem[8'h20];
        req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'd2; req_addr = 32'h80; req_wdata = 32'hDEADBEEF;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        n_vec++;
        if (mem_write_enable !== 4'b1111) begin n_fail++; $display("FAIL rst_issue_we got %b want 1111", mem_write_enable); end
        reset = 1'b1;
        #1;
        n_vec += 3;
        if (mem_write_enable !== 4'd0) begin n_fail++; $display("FAIL rst_we_async got %b want 0000", mem_write_enable); end
        if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_resp_valid got %b want 0", resp_valid); end
        if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_req_ready got %b want 1", req_ready); end
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            n_vec += 2;
            if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_no_resp c%0d got %b want 0", c, resp_valid); end
            if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready c%0d got %b want 1", c, req_ready); end
        end
        n_vec++;
        if (mem[8'h20] !== word_before) begin n_fail++; $display("FAIL rst_mem_unchanged got %h want %h", mem[8'h20], word_before); end
    endtask

    task automatic test_mem_image();
        int bad;
        bad = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) bad++;
        n_vec++;
        if (bad !== 0) begin n_fail++; $display("FAIL mem_image words_differing got %0d want 0", bad); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i] = $urandom;
            ref_mem[i] = mem[i];
        end
        req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'd0; req_addr = 32'd0; req_wdata = 32'd0;
        resp_ready = 1'b1;
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_reset_midop();
        test_mem_image();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
